// File: rtl/gfx_rom_loader.sv
// gfx_rom_loader
//   Claims one region of the serial graphics-ROM download stream, packs the
//   incoming bytes into LANES-byte words in a staging register and commits
//   each word to an internal RAM with a single byte-enabled write. The video
//   side reads the RAM through a registered (1-clock) read port.
//
// Ports
//   CL     in   clock (download and read sides)
//   RST_N  in   asynchronous active-low reset
//   ROMAD  in   [DLAW]     download byte address (top REGW bits = region)
//   ROMDT  in   [8]        download byte
//   ROMEN  in   1          download strobe, one byte per high cycle
//   FLUSH  in   1          forces commit of an open partial word
//   AD     in   [AW]       read word address
//   DT     out  [8*LANES]  read data, valid one clock after AD
//   BUSY   out  1          staging word open
//   WCNT   out  [16]       words committed since reset, saturating
module gfx_rom_loader #(
  parameter int DLAW   = 17,
  parameter int REGW   = 2,
  parameter int REGION = 0,
  parameter int LANES  = 4,
  parameter int AW     = 13,
  parameter bit BIGEND = 1'b0
) (
  input  logic                 CL,
  input  logic                 RST_N,
  input  logic [DLAW-1:0]      ROMAD,
  input  logic [7:0]           ROMDT,
  input  logic                 ROMEN,
  input  logic                 FLUSH,
  input  logic [AW-1:0]        AD,
  output logic [8*LANES-1:0]   DT,
  output logic                 BUSY,
  output logic [15:0]          WCNT
);

  localparam int OW  = DLAW - REGW;
  localparam int LB  = $clog2(LANES);
  localparam int LBW = (LB == 0) ? 1 : LB;

  typedef enum logic {EMPTY, FILL} state_t;

  state_t               state_q, state_d;
  logic [8*LANES-1:0]   stg_word_q, stg_word_d;
  logic [AW-1:0]        stg_addr_q, stg_addr_d;
  logic [LANES-1:0]     stg_mask_q, stg_mask_d;
  logic                 busy_q, busy_d;
  logic [15:0]          wcnt_q, wcnt_d;
  logic [8*LANES-1:0]   dt_q, dt_d;

  logic [8*LANES-1:0]   ram [2**AW];

  logic                 acc;
  logic [OW-1:0]        off;
  logic [AW-1:0]        word;
  logic [LBW-1:0]       lane;
  logic [LBW-1:0]       pos;
  logic [LANES-1:0]     byte_mask;
  logic [8*LANES-1:0]   byte_word;
  logic                 fire;

  // Decode the incoming byte. The lane is mapped to its physical byte
  // position here, so staging and RAM share one byte layout and the mask
  // doubles as the RAM byte enable.
  always_comb begin
    acc       = ROMEN && (ROMAD[DLAW-1 -: REGW] == REGW'(REGION));
    off       = ROMAD[OW-1:0];
    word      = AW'(off >> LB);
    lane      = LBW'(off & OW'(LANES - 1));
    pos       = BIGEND ? (LBW'(LANES - 1) - lane) : lane;
    byte_mask = LANES'(1) << pos;
    byte_word = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byte_mask[i]) byte_word[8*i +: 8] = ROMDT;
    end
  end

  always_comb begin
    state_d    = state_q;
    stg_word_d = stg_word_q;
    stg_addr_d = stg_addr_q;
    stg_mask_d = stg_mask_q;
    fire       = 1'b0;

    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d    = FILL;
          stg_word_d = byte_word;
          stg_addr_d = word;
          stg_mask_d = byte_mask;
        end
      end
      FILL: begin
        fire = (&stg_mask_q) || FLUSH ||
               (acc && ((word != stg_addr_q) || ((stg_mask_q & byte_mask) != '0)));
        if (fire) begin
          // A byte arriving with the commit starts the next word; it is
          // never merged into the word being written.
          if (acc) begin
            stg_word_d = byte_word;
            stg_addr_d = word;
            stg_mask_d = byte_mask;
          end else begin
            state_d    = EMPTY;
            stg_mask_d = '0;
          end
        end else if (acc) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (byte_mask[i]) stg_word_d[8*i +: 8] = ROMDT;
          end
          stg_mask_d = stg_mask_q | byte_mask;
        end
      end
      default: begin
        state_d    = EMPTY;
        stg_mask_d = '0;
      end
    endcase

    busy_d = (state_d == FILL);
    wcnt_d = (fire && (wcnt_q != 16'hFFFF)) ? wcnt_q + 16'd1 : wcnt_q;
    dt_d   = ram[AD];
  end

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= EMPTY;
      stg_word_q <= '0;
      stg_addr_q <= '0;
      stg_mask_q <= '0;
      busy_q     <= 1'b0;
      wcnt_q     <= '0;
      dt_q       <= '0;
    end else begin
      state_q    <= state_d;
      stg_word_q <= stg_word_d;
      stg_addr_q <= stg_addr_d;
      stg_mask_q <= stg_mask_d;
      busy_q     <= busy_d;
      wcnt_q     <= wcnt_d;
      dt_q       <= dt_d;
    end
  end

  // RAM is neither reset nor initialised; disabled lanes keep their contents.
  always_ff @(posedge CL) begin
    if (fire) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (stg_mask_q[i]) ram[stg_addr_q][8*i +: 8] <= stg_word_q[8*i +: 8];
      end
    end
  end

  assign DT   = dt_q;
  assign BUSY = busy_q;
  assign WCNT = wcnt_q;

endmodule

// File: tb/tb_gfx_rom_loader.sv
module tb_gfx_rom_loader;

  logic        CL = 1'b0;
  logic        RST_N;
  logic [16:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        ROMEN;
  logic        FLUSH;
  logic [12:0] AD;
  logic [31:0] DT_LE, DT_BE;
  logic        BUSY_LE, BUSY_BE;
  logic [15:0] WCNT_LE, WCNT_BE;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_wcnt = 16'd0;

  always #5 CL = ~CL;

  gfx_rom_loader #(.DLAW(17), .REGW(2), .REGION(1), .LANES(4), .AW(13), .BIGEND(1'b0)) dut_le (
    .CL(CL), .RST_N(RST_N), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .FLUSH(FLUSH), .AD(AD), .DT(DT_LE), .BUSY(BUSY_LE), .WCNT(WCNT_LE)
  );

  gfx_rom_loader #(.DLAW(17), .REGW(2), .REGION(1), .LANES(4), .AW(13), .BIGEND(1'b1)) dut_be (
    .CL(CL), .RST_N(RST_N), .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .FLUSH(FLUSH), .AD(AD), .DT(DT_BE), .BUSY(BUSY_BE), .WCNT(WCNT_BE)
  );

  // Advance one clock; observations are taken 1ns after the rising edge.
  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  // Present one byte for one clock (strobe stays high for back-to-back use).
  task automatic put(input logic [16:0] a, input logic [7:0] d);
    ROMAD = a;
    ROMDT = d;
    ROMEN = 1'b1;
    tick();
  endtask

  task automatic idle();
    ROMEN = 1'b0;
    FLUSH = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; ROMAD = '0; ROMDT = '0; ROMEN = 1'b0; FLUSH = 1'b0; AD = '0;
    tick(); tick();
    n_cmp++; if (DT_LE !== 32'h0) begin n_err++; $display("FAIL reset_dt: got %h want %h", DT_LE, 32'h0); end
    n_cmp++; if (BUSY_LE !== 1'b0 || BUSY_BE !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0", BUSY_LE, BUSY_BE); end
    n_cmp++; if (WCNT_LE !== 16'h0) begin n_err++; $display("FAIL reset_wcnt: got %h want 0", WCNT_LE); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_pack();
    put(17'h08000, 8'h11);
    put(17'h08001, 8'h22);
    put(17'h08002, 8'h33);
    put(17'h08003, 8'h44);
    ROMEN = 1'b0;
    n_cmp++; if (WCNT_LE !== exp_wcnt || BUSY_LE !== 1'b1) begin n_err++; $display("FAIL pack_before_commit: wcnt %h busy %b want %h 1", WCNT_LE, BUSY_LE, exp_wcnt); end
    tick();
    exp_wcnt = 16'd1;
    n_cmp++; if (WCNT_LE !== exp_wcnt || WCNT_BE !== exp_wcnt) begin n_err++; $display("FAIL pack_wcnt: got %h/%h want %h", WCNT_LE, WCNT_BE, exp_wcnt); end
    n_cmp++; if (BUSY_LE !== 1'b0) begin n_err++; $display("FAIL pack_busy: got %b want 0", BUSY_LE); end
    AD = 13'd0;
    tick();
    n_cmp++; if (DT_LE !== 32'h44332211) begin n_err++; $display("FAIL pack_le_dt: got %h want %h", DT_LE, 32'h44332211); end
    n_cmp++; if (DT_BE !== 32'h11223344) begin n_err++; $display("FAIL pack_be_dt: got %h want %h", DT_BE, 32'h11223344); end
  endtask

  task automatic test_partial();
    put(17'h08004, 8'h01);
    put(17'h08005, 8'h02);
    put(17'h08006, 8'h03);
    put(17'h08007, 8'h04);
    idle();
    exp_wcnt = 16'd2;
    AD = 13'd1;
    put(17'h08004, 8'hAA);
    put(17'h08005, 8'hBB);
    // The next edge commits word 1 while AD=1 is sampled: old data returns.
    put(17'h08010, 8'hCC);
    ROMEN = 1'b0;
    exp_wcnt = 16'd3;
    n_cmp++; if (DT_LE !== 32'h04030201) begin n_err++; $display("FAIL partial_rbw: got %h want %h", DT_LE, 32'h04030201); end
    n_cmp++; if (WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL partial_wcnt: got %h want %h", WCNT_LE, exp_wcnt); end
    n_cmp++; if (BUSY_LE !== 1'b1) begin n_err++; $display("FAIL partial_busy: got %b want 1", BUSY_LE); end
    tick();
    n_cmp++; if (DT_LE !== 32'h0403BBAA) begin n_err++; $display("FAIL partial_le_dt: got %h want %h", DT_LE, 32'h0403BBAA); end
    n_cmp++; if (DT_BE !== 32'hAABB0304) begin n_err++; $display("FAIL partial_be_dt: got %h want %h", DT_BE, 32'hAABB0304); end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    exp_wcnt = 16'd4;
    AD = 13'd4;
    tick();
    n_cmp++; if (DT_LE[7:0] !== 8'hCC || BUSY_LE !== 1'b0) begin n_err++; $display("FAIL partial_word4: dt %h busy %b want cc 0", DT_LE[7:0], BUSY_LE); end
  endtask

  task automatic test_flush();
    put(17'h08008, 8'h5A);
    ROMEN = 1'b0;
    tick(); tick();
    n_cmp++; if (BUSY_LE !== 1'b1 || WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL flush_pre: busy %b wcnt %h want 1 %h", BUSY_LE, WCNT_LE, exp_wcnt); end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    exp_wcnt = 16'd5;
    n_cmp++; if (BUSY_LE !== 1'b0 || WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL flush_post: busy %b wcnt %h want 0 %h", BUSY_LE, WCNT_LE, exp_wcnt); end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    AD = 13'd2;
    tick();
    n_cmp++; if (WCNT_LE !== exp_wcnt || BUSY_LE !== 1'b0) begin n_err++; $display("FAIL flush_empty: wcnt %h busy %b want %h 0", WCNT_LE, BUSY_LE, exp_wcnt); end
    n_cmp++; if (DT_LE[7:0] !== 8'h5A || DT_BE[31:24] !== 8'h5A) begin n_err++; $display("FAIL flush_data: got %h/%h want 5a", DT_LE[7:0], DT_BE[31:24]); end
  endtask

  task automatic test_ignored();
    put(17'h00000, 8'hEE);
    put(17'h18000, 8'hEE);
    put(17'h10001, 8'hEE);
    ROMEN = 1'b0;
    AD = 13'd0;
    n_cmp++; if (BUSY_LE !== 1'b0 || WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL ignored_state: busy %b wcnt %h want 0 %h", BUSY_LE, WCNT_LE, exp_wcnt); end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    tick();
    n_cmp++; if (DT_LE !== 32'h44332211 || WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL ignored_ram: dt %h wcnt %h want 44332211 %h", DT_LE, WCNT_LE, exp_wcnt); end
  endtask

  task automatic test_mid_reset();
    put(17'h08014, 8'h71);
    put(17'h08015, 8'h72);
    put(17'h08016, 8'h73);
    put(17'h08017, 8'h74);
    idle();
    put(17'h08014, 8'h61);
    put(17'h08015, 8'h62);
    put(17'h08016, 8'h63);
    ROMEN = 1'b0;
    RST_N = 1'b0;
    #1;
    n_cmp++; if (DT_LE !== 32'h0 || BUSY_LE !== 1'b0 || WCNT_LE !== 16'h0) begin n_err++; $display("FAIL mid_reset_async: dt %h busy %b wcnt %h want 0 0 0", DT_LE, BUSY_LE, WCNT_LE); end
    tick();
    RST_N = 1'b1;
    exp_wcnt = 16'd0;
    AD = 13'd5;
    tick();
    tick();
    n_cmp++; if (DT_LE !== 32'h74737271) begin n_err++; $display("FAIL mid_reset_nowrite: got %h want %h", DT_LE, 32'h74737271); end
    n_cmp++; if (WCNT_LE !== exp_wcnt || BUSY_LE !== 1'b0) begin n_err++; $display("FAIL mid_reset_state: wcnt %h busy %b want %h 0", WCNT_LE, BUSY_LE, exp_wcnt); end
    put(17'h08014, 8'h81);
    put(17'h08015, 8'h82);
    put(17'h08016, 8'h83);
    put(17'h08017, 8'h84);
    idle();
    exp_wcnt = 16'd1;
    tick();
    n_cmp++; if (DT_LE !== 32'h84838281 || WCNT_LE !== exp_wcnt) begin n_err++; $display("FAIL mid_reset_reload: dt %h wcnt %h want 84838281 %h", DT_LE, WCNT_LE, exp_wcnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      put(17'h08018 + 17'(i), 8'hA0 + 8'(i));
    end
    ROMEN = 1'b0;
    exp_wcnt = 16'd2;
    n_cmp++; if (WCNT_LE !== exp_wcnt || BUSY_LE !== 1'b1) begin n_err++; $display("FAIL b2b_mid: wcnt %h busy %b want %h 1", WCNT_LE, BUSY_LE, exp_wcnt); end
    tick();
    exp_wcnt = 16'd3;
    n_cmp++; if (WCNT_LE !== exp_wcnt || BUSY_LE !== 1'b0) begin n_err++; $display("FAIL b2b_end: wcnt %h busy %b want %h 0", WCNT_LE, BUSY_LE, exp_wcnt); end
    AD = 13'd6;
    tick();
    n_cmp++; if (DT_LE !== 32'hA3A2A1A0) begin n_err++; $display("FAIL b2b_word6: got %h want %h", DT_LE, 32'hA3A2A1A0); end
    AD = 13'd7;
    tick();
    n_cmp++; if (DT_LE !== 32'hA7A6A5A4) begin n_err++; $display("FAIL b2b_word7: got %h want %h", DT_LE, 32'hA7A6A5A4); end
    n_cmp++; if (DT_BE !== 32'hA4A5A6A7) begin n_err++; $display("FAIL b2b_word7_be: got %h want %h", DT_BE, 32'hA4A5A6A7); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_partial();
    test_flush();
    test_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
